// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scancode receiver:
//   - ps2_state_t      : frame FSM states (IDLE, DATA, PARITY, STOP)
//   - PS2_PREFIX_EXT   : extended-key prefix byte (E0)
//   - PS2_PREFIX_BREAK : key-release prefix byte (F0)
//   - PS2_FRAME_BITS   : bits per device-to-host frame (start+8+parity+stop)
//   - odd_parity_ok()  : odd-parity check over data byte plus parity bit
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 11;

    // True when data plus parity contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ----------------------------------------------------------------------------
// ps2_line_filter
// Synchronizes the raw PS/2 clock into the pclk domain and deglitches it: the
// filtered level only follows the synchronized input once the two have
// differed for FILTER_LEN consecutive cycles. Emits a registered one-cycle
// pulse when the filtered level falls 1 -> 0.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_line  : raw asynchronous line
//   o_fall  : one-cycle pulse on a filtered falling edge
// Synchronizer and filtered level reset to 1 so an idle bus gives no edge.
// ----------------------------------------------------------------------------
import ps2_pkg::*;

module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_fall = r_fall;

    // Synchronizer chain plus stability counter and filtered level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_filt <= 1'b1;
            r_cnt  <= '0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_fall <= 1'b0;
            if (w_sync != r_filt) begin
                // Last of FILTER_LEN differing cycles: accept the new level.
                if (r_cnt == CNT_LAST) begin
                    r_filt <= w_sync;
                    r_cnt  <= '0;
                    r_fall <= ~w_sync;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx
// PS/2 device-to-host frame receiver. Deserializes 11-bit frames sampled on
// filtered ps2_clk falling edges, folds E0/F0 prefixes into flags and emits a
// single strobe per key event.
// Ports:
//   pclk           : system clock (65 MHz)
//   rst            : asynchronous active-low reset
//   ps2_clk        : raw PS/2 clock
//   ps2_data       : raw PS/2 data
//   scancode       : last completed non-prefix byte (held between strobes)
//   scancode_valid : one-cycle strobe qualifying scancode/is_break/is_extended
//   is_break       : F0 preceded this byte
//   is_extended    : E0 preceded this byte
//   frame_err      : one-cycle strobe on stop-bit, parity or timeout error
// Configuration macro: PS2_PARITY_CHECK_EN -- when defined, a parity mismatch
// rejects the frame; otherwise the parity bit is sampled but ignored.
// ----------------------------------------------------------------------------
import ps2_pkg::*;

module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    // Index of the last data bit: frame minus start, parity and stop, minus one.
    localparam logic [2:0] DATA_LAST = 3'(PS2_FRAME_BITS - 4);

    logic                   w_fall;
    logic                   w_data;
    logic [SYNC_STAGES-1:0] r_dsync;

    ps2_state_t r_state, w_state_nxt;
    logic [2:0]       r_bit_cnt,  w_bit_cnt_nxt;
    logic [7:0]       r_shift,    w_shift_nxt;
    logic             r_parity,   w_parity_nxt;
    logic [TMO_W-1:0] r_tmo_cnt,  w_tmo_cnt_nxt;
    logic             r_ext,      w_ext_nxt;
    logic             r_brk,      w_brk_nxt;
    logic [7:0]       r_scancode, w_scancode_nxt;
    logic             r_valid,    w_valid_nxt;
    logic             r_is_brk,   w_is_brk_nxt;
    logic             r_is_ext,   w_is_ext_nxt;
    logic             r_err,      w_err_nxt;
    logic             w_good;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .i_clk   (pclk),
        .i_rst_n (rst),
        .i_line  (ps2_clk),
        .o_fall  (w_fall)
    );

    // Data line only needs synchronizing; it is sampled on filtered clock edges.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_dsync <= '1;
        end else begin
            r_dsync <= {r_dsync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign w_data = r_dsync[SYNC_STAGES-1];

    // Frame acceptance: w_data here is the stop bit being sampled in ST_STOP.
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        w_good = w_data & odd_parity_ok(r_shift, r_parity);
`else
        // Parity is captured but deliberately masked out of the verdict.
        w_good = w_data & (odd_parity_ok(r_shift, r_parity) | 1'b1);
`endif
    end

    // Next-state, deserializer, prefix flags, timeout and output strobes.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_ext_nxt      = r_ext;
        w_brk_nxt      = r_brk;
        w_scancode_nxt = r_scancode;
        w_is_brk_nxt   = r_is_brk;
        w_is_ext_nxt   = r_is_ext;
        w_valid_nxt    = 1'b0;
        w_err_nxt      = 1'b0;

        if (w_fall) begin
            // An edge always restarts the timeout, even on its terminal count.
            w_tmo_cnt_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        w_state_nxt   = ST_DATA;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt   = {w_data, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == DATA_LAST) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    w_parity_nxt = w_data;
                    w_state_nxt  = ST_STOP;
                end
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (!w_good) begin
                        w_err_nxt = 1'b1;
                        w_ext_nxt = 1'b0;
                        w_brk_nxt = 1'b0;
                    end else if (r_shift == PS2_PREFIX_EXT) begin
                        w_ext_nxt = 1'b1;
                    end else if (r_shift == PS2_PREFIX_BREAK) begin
                        w_brk_nxt = 1'b1;
                    end else begin
                        w_scancode_nxt = r_shift;
                        w_is_brk_nxt   = r_brk;
                        w_is_ext_nxt   = r_ext;
                        w_valid_nxt    = 1'b1;
                        w_ext_nxt      = 1'b0;
                        w_brk_nxt      = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (r_state != ST_IDLE) begin
            if (r_tmo_cnt == TMO_LAST) begin
                w_state_nxt   = ST_IDLE;
                w_tmo_cnt_nxt = '0;
                w_err_nxt     = 1'b1;
                w_ext_nxt     = 1'b0;
                w_brk_nxt     = 1'b0;
            end else begin
                w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
            end
        end else begin
            w_tmo_cnt_nxt = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_parity   <= 1'b0;
            r_tmo_cnt  <= '0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_scancode <= 8'h00;
            r_valid    <= 1'b0;
            r_is_brk   <= 1'b0;
            r_is_ext   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_ext      <= w_ext_nxt;
            r_brk      <= w_brk_nxt;
            r_scancode <= w_scancode_nxt;
            r_valid    <= w_valid_nxt;
            r_is_brk   <= w_is_brk_nxt;
            r_is_ext   <= w_is_ext_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign scancode       = r_scancode;
    assign scancode_valid = r_valid;
    assign is_break       = r_is_brk;
    assign is_extended    = r_is_ext;
    assign frame_err      = r_err;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_rx
// Scoreboard bench for ps2_scancode_rx. Stimulus tasks drive PS/2 frames and
// push the expected event (strobe or error, byte, flags, latency from the
// last raw ps2_clk fall) computed from the protocol rules; a monitor pops and
// compares whenever the DUT raises scancode_valid or frame_err.
// Honors PS2_PARITY_CHECK_EN the same way the design does.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_scancode_rx;

    localparam int HP       = 12;
    localparam int LAT      = 2 + 8 + 1;
    localparam int TMO      = 65000;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
        int         lat;
    } exp_t;

    logic       pclk = 1'b0;
    logic       rst  = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_fall = 0;
    bit   m_ext = 1'b0;
    bit   m_brk = 1'b0;

    ps2_scancode_rx dut (
        .pclk           (pclk),
        .rst            (rst),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .is_break       (is_break),
        .is_extended    (is_extended),
        .frame_err      (frame_err)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: every DUT strobe must match the oldest expected event.
    always @(negedge pclk) begin
        if (scancode_valid || frame_err) begin
            check("no_overlap", int'(scancode_valid && frame_err), 0);
            if (q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_kind", int'(frame_err), int'(e.err));
                check("latency", cyc - last_fall, e.lat);
                if (!e.err) begin
                    check("scancode", int'(scancode), int'(e.code));
                    check("is_break", int'(is_break), int'(e.brk));
                    check("is_extended", int'(is_extended), int'(e.ext));
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // Drive the first nbits of a frame, LSB (start bit) first.
    task automatic drive_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            wait_cycles(HP / 2);
            ps2_data = bits[i];
            wait_cycles(HP / 2);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cycles(HP);
            ps2_clk = 1'b1;
        end
        wait_cycles(HP / 2);
        ps2_data = 1'b1;
    endtask

    // Full frame with reference-model bookkeeping.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        logic stp;
        bit   good;
        exp_t e;
        par  = ~(^b) ^ bad_par;
        stp  = ~bad_stop;
`ifdef PS2_PARITY_CHECK_EN
        good = !bad_stop && !bad_par;
`else
        good = !bad_stop;
`endif
        if (!good) begin
            e = '{err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0, lat: LAT};
            q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            e = '{err: 1'b0, code: b, brk: m_brk, ext: m_ext, lat: LAT};
            q.push_back(e);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        drive_bits({stp, par, b, 1'b0}, 11);
        wait_cycles(30);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_scancode"}, int'(scancode), 0);
        check({tag, "_valid"}, int'(scancode_valid), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_is_break"}, int'(is_break), 0);
        check({tag, "_is_extended"}, int'(is_extended), 0);
    endtask

    initial begin
        exp_t e;
        logic [7:0] b;
        int r;
        int budget;

        wait_cycles(5);
        check_reset_outputs("reset");
        rst = 1'b1;
        wait_cycles(40);
        check_reset_outputs("idle_after_reset");

        // Directed sequences.
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);

        // Short low glitch on ps2_clk while idle: must be filtered away.
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(40);
        check("glitch_queue_empty", q.size(), 0);

        // Randomized frames, prefixes weighted up.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        // Truncated frame: start plus 4 data bits, then idle until timeout.
        send_frame(8'hE0, 1'b0, 1'b0);
        e = '{err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0, lat: LAT + TMO};
        q.push_back(e);
        m_ext = 1'b0;
        m_brk = 1'b0;
        drive_bits(11'b000_0001_1100 << 0, 5);
        wait_cycles(TMO + 40);
        check("timeout_drained", q.size(), 0);
        send_frame(8'h1C, 1'b0, 1'b0);

        // Reset in the middle of a frame after a pending break prefix.
        send_frame(8'hF0, 1'b0, 1'b0);
        drive_bits(11'b000_0010_1010, 4);
        rst = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_cycles(3);
        check_reset_outputs("mid_frame_reset");
        rst = 1'b1;
        wait_cycles(40);
        check_reset_outputs("after_mid_frame_reset");
        send_frame(8'h1C, 1'b0, 1'b0);

        // Bounded drain of anything still outstanding.
        budget = 200;
        while (q.size() != 0 && budget > 0) begin
            wait_cycles(1);
            budget--;
        end
        check("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
